// File: rtl/ladybird_config.sv
// ladybird_config: shared constants, state enum and cause encoding for the ladybird interrupt controller
package ladybird_config;
  localparam int XLEN = 32;
  localparam logic [1:0] PRIV_MODE_U = 2'b00;
  localparam logic [1:0] PRIV_MODE_S = 2'b01;
  localparam logic [1:0] PRIV_MODE_M = 2'b11;
  localparam logic [11:0] CSR_ADDR_M_IE       = 12'h304;
  localparam logic [11:0] CSR_ADDR_M_IP       = 12'h344;
  localparam logic [11:0] CSR_ADDR_M_TIMECMP  = 12'h7c0;
  localparam logic [11:0] CSR_ADDR_M_TIMECMPH = 12'h7c1;
  localparam logic [11:0] CSR_ADDR_M_MSIP     = 12'h7c2;
  localparam int IRQ_CODE_MSI = 3;
  localparam int IRQ_CODE_MTI = 7;
  localparam int IRQ_CODE_MEI = 11;
  localparam logic [XLEN-1:0] MIE_MASK = XLEN'((1 << IRQ_CODE_MSI) | (1 << IRQ_CODE_MTI) | (1 << IRQ_CODE_MEI));
  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_HOLDOFF} irq_state_e;
  // Highest-priority pending source wins: MEI, then MSI, then MTI.
  function automatic logic [XLEN-1:0] irq_cause_of(input logic [XLEN-1:0] cand);
    return cand[IRQ_CODE_MEI] ? {1'b1, (XLEN-1)'(IRQ_CODE_MEI)} :
           cand[IRQ_CODE_MSI] ? {1'b1, (XLEN-1)'(IRQ_CODE_MSI)} :
           cand[IRQ_CODE_MTI] ? {1'b1, (XLEN-1)'(IRQ_CODE_MTI)} : '0;
  endfunction
endpackage

// File: rtl/ladybird_irq_ctrl.sv
// ladybird_irq_ctrl: machine-level interrupt CSRs, timer compare and request/ack handshake FSM
module ladybird_irq_ctrl
  import ladybird_config::*;
#(
  parameter int HART_ID = 0,
  parameter logic [63:0] MTIMECMP_INIT = '1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [63:0]     rtc,
  input  logic [1:0]      mode,
  input  logic            m_ie,
  input  logic            ext_irq,
  input  logic            wr_valid,
  input  logic [11:0]     wr_addr,
  input  logic [XLEN-1:0] wr_data,
  input  logic [11:0]     rd_addr,
  output logic [XLEN-1:0] rd_data,
  output logic            irq_req,
  output logic [XLEN-1:0] irq_cause,
  input  logic            irq_ack
);
  logic            ext_q;
  logic            msip;
  logic [XLEN-1:0] mie;
  logic [63:0]     mtimecmp;
  logic [XLEN-1:0] mip;
  logic [XLEN-1:0] cand;
  irq_state_e      state;

  assign mip  = XLEN'({ext_q, 3'b0, rtc >= mtimecmp, 3'b0, msip, 3'b0});
  assign cand = ((mode != PRIV_MODE_M) | m_ie) ? (mip & mie) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      ext_q    <= 1'b0;
      msip     <= 1'b0;
      mie      <= '0;
      mtimecmp <= MTIMECMP_INIT;
    end else begin
      ext_q <= ext_irq;
      if (wr_valid) begin
        if (wr_addr == CSR_ADDR_M_IE) mie <= wr_data & MIE_MASK;
        if (wr_addr == CSR_ADDR_M_MSIP) msip <= wr_data[0];
        if (wr_addr == CSR_ADDR_M_TIMECMP) mtimecmp[31:0] <= wr_data[31:0];
        if (wr_addr == CSR_ADDR_M_TIMECMPH) mtimecmp[63:32] <= wr_data[31:0];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    case (rd_addr)
      CSR_ADDR_M_IE:       rd_data = mie;
      CSR_ADDR_M_IP:       rd_data = mip;
      CSR_ADDR_M_TIMECMP:  rd_data = XLEN'(mtimecmp[31:0]);
      CSR_ADDR_M_TIMECMPH: rd_data = XLEN'(mtimecmp[63:32]);
      CSR_ADDR_M_MSIP:     rd_data = XLEN'(msip);
      default:             rd_data = '0;
    endcase
  end

  // Ack wins over withdrawal; HOLDOFF gives the CSR one cycle to clear MIE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      irq_req   <= 1'b0;
      irq_cause <= '0;
    end else begin
      case (state)
        ST_IDLE:
          if (|cand) begin
            state     <= ST_REQ;
            irq_req   <= 1'b1;
            irq_cause <= irq_cause_of(cand);
          end
        ST_REQ:
          if (irq_ack) begin
            state   <= ST_HOLDOFF;
            irq_req <= 1'b0;
          end else if (~|cand) begin
            state   <= ST_IDLE;
            irq_req <= 1'b0;
          end else begin
            irq_cause <= irq_cause_of(cand);
          end
        default: begin
          state   <= ST_IDLE;
          irq_req <= 1'b0;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk)
    if (!rst && irq_ack && state != ST_REQ)
      $warning("hart %0d: irq_ack outside request ignored", HART_ID);
`endif
endmodule

// File: tb/tb_ladybird_irq_ctrl.sv
// tb_ladybird_irq_ctrl: table vectors, directed corner sequences and random stimulus against a behavioural model
module tb_ladybird_irq_ctrl;
  import ladybird_config::*;
  logic clk = 1'b0;
  logic rst, m_ie, ext_irq, wr_valid, irq_ack, irq_req;
  logic [63:0] rtc;
  logic [1:0] mode;
  logic [11:0] wr_addr, rd_addr;
  logic [31:0] wr_data, rd_data, irq_cause;
  int n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  ladybird_irq_ctrl #(.HART_ID(0)) dut (
    .clk(clk), .rst(rst), .rtc(rtc), .mode(mode), .m_ie(m_ie), .ext_irq(ext_irq),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(rd_addr),
    .rd_data(rd_data), .irq_req(irq_req), .irq_cause(irq_cause), .irq_ack(irq_ack)
  );

  logic [31:0] m_mie, m_cause;
  logic [63:0] m_cmp;
  logic m_msip, m_ext, m_req, m_cool;

  function automatic logic [31:0] m_pending();
    return ({31'b0, m_ext} << 11) | ({31'b0, rtc >= m_cmp} << 7) | ({31'b0, m_msip} << 3);
  endfunction

  function automatic logic [31:0] m_best(input logic [31:0] c);
    int prio [3] = '{11, 3, 7};
    for (int i = 0; i < 3; i++)
      if (c[prio[i]]) return 32'h8000_0000 | 32'(prio[i]);
    return 32'h0;
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      CSR_ADDR_M_IE:       return m_mie;
      CSR_ADDR_M_IP:       return m_pending();
      CSR_ADDR_M_TIMECMP:  return m_cmp[31:0];
      CSR_ADDR_M_TIMECMPH: return m_cmp[63:32];
      CSR_ADDR_M_MSIP:     return {31'b0, m_msip};
      default:             return 32'h0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    logic [31:0] cand;
    cand = ((mode != PRIV_MODE_M) || m_ie) ? (m_pending() & m_mie) : 32'h0;
    if (rst) begin
      m_req = 0; m_cool = 0; m_cause = 0;
    end else if (m_cool) m_cool = 0;
    else if (m_req) begin
      if (irq_ack) begin m_req = 0; m_cool = 1; end
      else if (cand == 0) m_req = 0;
      else m_cause = m_best(cand);
    end else if (cand != 0) begin
      m_req = 1; m_cause = m_best(cand);
    end
    if (rst) begin
      m_mie = 0; m_msip = 0; m_ext = 0; m_cmp = '1;
    end else begin
      m_ext = ext_irq;
      if (wr_valid) begin
        if (wr_addr == CSR_ADDR_M_IE) m_mie = wr_data & 32'h888;
        if (wr_addr == CSR_ADDR_M_MSIP) m_msip = wr_data[0];
        if (wr_addr == CSR_ADDR_M_TIMECMP) m_cmp[31:0] = wr_data;
        if (wr_addr == CSR_ADDR_M_TIMECMPH) m_cmp[63:32] = wr_data;
      end
    end
    @(posedge clk);
    #1;
    check("model_irq_req", 32'(irq_req), 32'(m_req));
    check("model_irq_cause", irq_cause, m_cause);
    check("model_rd_data", rd_data, m_read(rd_addr));
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    wr_valid = 1; wr_addr = a; wr_data = d;
    tick();
    wr_valid = 0;
  endtask

  task automatic do_reset();
    rst = 1; tick(); tick(); rst = 0;
  endtask

  typedef struct {
    logic        wv;
    logic [11:0] wa;
    logic [31:0] wd;
    logic [11:0] ra;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [9];

  logic [11:0] addrs [6];
  bit seen;

  initial begin
    tbl[0] = '{1'b1, CSR_ADDR_M_IE,       32'hffff_ffff, CSR_ADDR_M_IE,       32'h0000_0888};
    tbl[1] = '{1'b1, CSR_ADDR_M_MSIP,     32'h0000_0003, CSR_ADDR_M_MSIP,     32'h0000_0001};
    tbl[2] = '{1'b1, CSR_ADDR_M_IP,       32'h0000_ffff, CSR_ADDR_M_IP,       32'h0000_0008};
    tbl[3] = '{1'b1, CSR_ADDR_M_TIMECMP,  32'h1234_5678, CSR_ADDR_M_TIMECMP,  32'h1234_5678};
    tbl[4] = '{1'b1, CSR_ADDR_M_TIMECMPH, 32'h0000_0000, CSR_ADDR_M_TIMECMPH, 32'h0000_0000};
    tbl[5] = '{1'b0, CSR_ADDR_M_IE,       32'h0000_0000, 12'h123,             32'h0000_0000};
    tbl[6] = '{1'b1, CSR_ADDR_M_MSIP,     32'h0000_0000, CSR_ADDR_M_IP,       32'h0000_0000};
    tbl[7] = '{1'b1, CSR_ADDR_M_TIMECMP,  32'h0000_0000, CSR_ADDR_M_IP,       32'h0000_0080};
    tbl[8] = '{1'b1, CSR_ADDR_M_IE,       32'h0000_0000, CSR_ADDR_M_IE,       32'h0000_0000};
    addrs = '{CSR_ADDR_M_IE, CSR_ADDR_M_IP, CSR_ADDR_M_TIMECMP, CSR_ADDR_M_TIMECMPH, CSR_ADDR_M_MSIP, 12'h123};
    rst = 1; rtc = 0; mode = PRIV_MODE_M; m_ie = 0; ext_irq = 0; wr_valid = 0;
    wr_addr = 0; wr_data = 0; rd_addr = CSR_ADDR_M_IE; irq_ack = 0;
    m_req = 0; m_cool = 0; m_cause = 0; m_mie = 0; m_msip = 0; m_ext = 0; m_cmp = '1;
    do_reset();
    check("reset_irq_req", 32'(irq_req), 32'h0);
    check("reset_irq_cause", irq_cause, 32'h0);
    check("reset_mie", rd_data, 32'h0);
    rd_addr = CSR_ADDR_M_TIMECMPH; #1;
    check("reset_timecmph", rd_data, 32'hffff_ffff);

    for (int i = 0; i < 9; i++) begin
      wr_valid = tbl[i].wv; wr_addr = tbl[i].wa; wr_data = tbl[i].wd; rd_addr = tbl[i].ra;
      tick();
      wr_valid = 0;
      check($sformatf("vec%0d_rd", i), rd_data, tbl[i].exp);
      check($sformatf("vec%0d_req", i), 32'(irq_req), 32'h0);
    end

    // MTIP pending with global enable off, then enabled by leaving M-mode
    wr(CSR_ADDR_M_IE, 32'h80);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("gate_no_req", 32'(irq_req), 32'h0);
    end
    mode = PRIV_MODE_U;
    seen = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (irq_req) seen = 1;
    end
    check("gate_user_req", 32'(seen), 32'h1);
    check("gate_user_cause", irq_cause, 32'h8000_0007);

    // reset while requesting
    rst = 1; rd_addr = CSR_ADDR_M_IE;
    tick();
    rst = 0;
    check("rst_mid_req", 32'(irq_req), 32'h0);
    check("rst_mid_mie", rd_data, 32'h0);
    rd_addr = CSR_ADDR_M_TIMECMP; #1;
    check("rst_mid_cmp_lo", rd_data, 32'hffff_ffff);
    rd_addr = CSR_ADDR_M_TIMECMPH; #1;
    check("rst_mid_cmp_hi", rd_data, 32'hffff_ffff);

    // timer ramp
    mode = PRIV_MODE_M; m_ie = 1;
    wr(CSR_ADDR_M_TIMECMPH, 32'h0);
    wr(CSR_ADDR_M_TIMECMP, 32'd100);
    wr(CSR_ADDR_M_IE, 32'h80);
    for (int r = 95; r <= 100; r++) begin
      rtc = 64'(r);
      tick();
      check($sformatf("timer_rtc%0d", r), 32'(irq_req), (r == 100) ? 32'h1 : 32'h0);
    end
    check("timer_cause", irq_cause, 32'h8000_0007);

    // ack handshake: holdoff, idle, re-raise
    irq_ack = 1; tick(); irq_ack = 0;
    check("ack_drop", 32'(irq_req), 32'h0);
    tick();
    check("ack_holdoff_idle", 32'(irq_req), 32'h0);
    tick();
    check("ack_reraise", 32'(irq_req), 32'h1);

    // withdrawal: mie cleared without ack goes straight to idle
    wr(CSR_ADDR_M_IE, 32'h0);
    check("wd_still_req", 32'(irq_req), 32'h1);
    wr(CSR_ADDR_M_IE, 32'h80);
    check("wd_dropped", 32'(irq_req), 32'h0);
    tick();
    check("wd_no_holdoff", 32'(irq_req), 32'h1);

    // stray ack in idle is ignored
    wr(CSR_ADDR_M_IE, 32'h0);
    tick();
    irq_ack = 1; tick(); irq_ack = 0;
    check("stray_ack", 32'(irq_req), 32'h0);
    wr(CSR_ADDR_M_IE, 32'h80);
    tick();
    check("stray_ack_then_req", 32'(irq_req), 32'h1);

    // priority MEI over MSI, then MSI after ack
    do_reset();
    rtc = 0;
    wr(CSR_ADDR_M_IE, 32'h888);
    ext_irq = 1;
    wr(CSR_ADDR_M_MSIP, 32'h1);
    tick();
    check("prio_req", 32'(irq_req), 32'h1);
    check("prio_mei", irq_cause, 32'h8000_000b);
    irq_ack = 1; ext_irq = 0; tick(); irq_ack = 0;
    tick(); tick();
    check("prio_msi_req", 32'(irq_req), 32'h1);
    check("prio_msi", irq_cause, 32'h8000_0003);
    ext_irq = 1; tick(); tick();
    check("prio_upgrade", irq_cause, 32'h8000_000b);
    ext_irq = 0;

    // randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      mode = 2'($urandom_range(0, 3));
      m_ie = 1'($urandom_range(0, 1));
      ext_irq = ($urandom_range(0, 3) == 0);
      wr_valid = ($urandom_range(0, 2) == 0);
      wr_addr = addrs[$urandom_range(0, 5)];
      wr_data = $urandom;
      if (wr_addr == CSR_ADDR_M_TIMECMP) wr_data = 32'($urandom_range(0, 400));
      if (wr_addr == CSR_ADDR_M_TIMECMPH && $urandom_range(0, 3) != 0) wr_data = 0;
      rd_addr = addrs[$urandom_range(0, 5)];
      rtc = ($urandom_range(0, 49) == 0) ? 64'($urandom_range(0, 400)) : rtc + 64'($urandom_range(0, 3));
      irq_ack = m_req && ($urandom_range(0, 1) == 1);
      tick();
    end
    rst = 0; irq_ack = 0; wr_valid = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ladybird_irq_ctrl.md
LADYBIRD_IRQ_CTRL -- requirements
Module: ladybird_irq_ctrl

Interface
REQ-001 SHALL have parameter HART_ID, default 0, hart identifier used only in simulation messages.
REQ-002 SHALL have parameter MTIMECMP_INIT, default all ones (64 bits), reset value of mtimecmp.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 rtc  input  64  free-running real-time counter.
REQ-006 mode  input  2  current privilege mode (PRIV_MODE_*).
REQ-007 m_ie  input  1  mstatus.MIE.
REQ-008 ext_irq  input  1  external interrupt level, synchronous to clk.
REQ-009 wr_valid  input  1  register write strobe.
REQ-010 wr_addr  input  12  write address (CSR space).
REQ-011 wr_data  input  XLEN  write data, already op-masked.
REQ-012 rd_addr  input  12  combinational read address.
REQ-013 rd_data  output  XLEN  read data.
REQ-014 irq_req  output  1  interrupt request to commit/CSR.
REQ-015 irq_cause  output  XLEN  mcause value for the request.
REQ-016 irq_ack  input  1  commit has taken the interrupt this cycle.

Function
REQ-017 SHALL hold mie with writable bits MSIE[3], MTIE[7], MEIE[11] only; other bits read 0.
REQ-018 SHALL form mip live: MEIP[11] = ext_irq registered one cycle; MTIP[7] = (rtc >= mtimecmp), 64-bit unsigned; MSIP[3] = msip register.
REQ-019 SHALL write mtimecmp[31:0] at CSR_ADDR_M_TIMECMP, mtimecmp[63:32] at CSR_ADDR_M_TIMECMPH, msip (wr_data[0]) at CSR_ADDR_M_MSIP, mie at CSR_ADDR_M_IE; writes to mip ignored.
REQ-020 SHALL return mie, mip, mtimecmp halves and msip on rd_data combinationally; unknown rd_addr returns 0.
REQ-021 Global enable SHALL be (mode != PRIV_MODE_M) | m_ie; candidate set = mip & mie, gated by global enable.
REQ-022 Priority SHALL be MEI > MSI > MTI; cause = {1'b1, code} with code 11, 3, 7 respectively, zero-extended to XLEN.
REQ-023 FSM states: IDLE, REQ, HOLDOFF.
REQ-024 IDLE: irq_req=0; any candidate -> REQ next cycle, latching the highest-priority cause into irq_cause.
REQ-025 REQ: irq_req=1, irq_cause stable; irq_ack -> HOLDOFF; no ack and candidate set empty (source dropped, enable cleared) -> IDLE, request withdrawn; no ack and higher-priority candidate appears -> stay REQ, irq_cause updates next cycle.
REQ-026 irq_ack and withdrawal condition in the same cycle SHALL resolve as ack (-> HOLDOFF).
REQ-027 HOLDOFF: irq_req=0 for exactly one cycle, then IDLE; covers the CSR clearing MIE.
REQ-028 irq_ack outside REQ SHALL be ignored (simulation warning).
REQ-029 Request latency: candidate becomes true at edge N -> irq_req high after edge N+1; ext_irq adds one synchronizer cycle.
REQ-030 Write to mtimecmp half SHALL affect MTIP on the cycle after the write edge; intermediate half-written values are architecturally visible (software writes hi=all-ones first).

Reset
REQ-031 On rst: state IDLE, irq_req=0, irq_cause=0, mie=0, msip=0, ext_irq register=0, mtimecmp=MTIMECMP_INIT.
REQ-032 rst asserted in REQ SHALL drop irq_req the following cycle with no ack required.

Structure
REQ-033 CSR_ADDR_M_IE, CSR_ADDR_M_IP, CSR_ADDR_M_TIMECMP(H), CSR_ADDR_M_MSIP, IRQ code constants (11/3/7) and the FSM state enum SHALL live in ladybird_config.
REQ-034 SHALL be a single module; no sub-module; implementation 150-300 lines.

Verification
REQ-035 Timer: mie=0x80, m_ie=1, mtimecmp=100, rtc ramps from 95 -> irq_req rises the cycle after rtc=100, irq_cause=0x80000007.
REQ-036 Priority: mie=0x888, msip=1 and ext_irq=1 together -> irq_cause=0x8000000B; after ack and ext_irq=0 -> next request cause 0x80000003.
REQ-037 Withdrawal: in REQ, write mie=0 without ack -> irq_req low next cycle, state IDLE, no HOLDOFF.
REQ-038 Handshake: ack in REQ -> irq_req low exactly one cycle, re-raised afterwards if m_ie still 1 and source pending.
REQ-039 Mode gating: m_ie=0, mode=PRIV_MODE_M, MTIP pending -> no request; switch mode to PRIV_MODE_U -> irq_req within 2 cycles.
REQ-040 Reset mid-request: rst in REQ -> irq_req=0, mie=0, mtimecmp=0xFFFFFFFF_FFFFFFFF next cycle.
